fll_cfg_arbiter: RTL and testbench

- Round-robin arbiter and sequencer sharing one FLL configuration port among NR_REQ requesters, for example the APB FLL interface and an on-chip DVFS controller.
- The configuration port uses a req/ack/addr/wdata/rdata/web interface.
- Each requester's access is serialised into one four-phase transaction on the FLL port, and its completion and read data are returned to that requester.
- Sits between the register-side masters and the FLL macro's CFG interface.

---
 rtl/fll_cfg_arbiter.sv | 147 ++++++++++++++
 tb/tb_fll_cfg_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fll_cfg_arbiter.sv
// Round-robin arbiter serialising NR_REQ requesters onto one four-phase FLL CFG port.
// Optional ISSUE watchdog enabled by defining FLL_CFG_ARB_TIMEOUT_EN.
module fll_cfg_arbiter #(
  parameter int unsigned NR_REQ     = 2,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 1024,
  localparam int unsigned IDW       = $clog2(NR_REQ)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NR_REQ-1:0]                    req_i,
  input  logic [NR_REQ-1:0][ADDR_WIDTH-1:0]    addr_i,
  input  logic [NR_REQ-1:0][DATA_WIDTH-1:0]    wdata_i,
  input  logic [NR_REQ-1:0]                    web_i,
  output logic [NR_REQ-1:0]                    ack_o,
  output logic [DATA_WIDTH-1:0]                rdata_o,
  output logic [NR_REQ-1:0]                    err_o,
  output logic                                 busy_o,
  output logic [IDW-1:0]                       gnt_id_o,
  output logic                                 fll_req_o,
  input  logic                                 fll_ack_i,
  output logic [ADDR_WIDTH-1:0]                fll_addr_o,
  output logic [DATA_WIDTH-1:0]                fll_wdata_o,
  output logic                                 fll_web_o,
  input  logic [DATA_WIDTH-1:0]                fll_rdata_i
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]            r_state;
  logic [IDW-1:0]        r_ptr;
  logic [IDW-1:0]        r_gnt;
  logic                  r_req;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_web;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [NR_REQ-1:0]     r_ack;

  logic                  w_found;
  logic [IDW-1:0]        w_win;
  logic [IDW-1:0]        w_idx;
  logic [IDW-1:0]        w_ptr_nxt;

  // First active requester at or after the pointer, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    w_idx   = r_ptr;
    for (int unsigned i = 0; i < NR_REQ; i++) begin
      w_idx = IDW'((32'(r_ptr) + i) % NR_REQ);
      if (!w_found && req_i[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_ptr_nxt = (w_win == IDW'(NR_REQ - 1)) ? '0 : w_win + 1'b1;

`ifdef FLL_CFG_ARB_TIMEOUT_EN
  localparam int unsigned CNTW = $clog2(TIMEOUT + 1);
  logic [CNTW-1:0]   r_cnt;
  logic [NR_REQ-1:0] r_err;
  assign err_o = r_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
  assign err_o = '0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_web   <= 1'b1;
      r_rdata <= '0;
      r_ack   <= '0;
`ifdef FLL_CFG_ARB_TIMEOUT_EN
      r_cnt   <= '0;
      r_err   <= '0;
`endif
    end else begin
      r_ack <= '0;
`ifdef FLL_CFG_ARB_TIMEOUT_EN
      r_err <= '0;
`endif
      case (r_state)
        S_IDLE: begin
          // A stale ack from the previous transfer blocks any new grant.
          if (w_found && !fll_ack_i) begin
            r_state <= S_ISSUE;
            r_req   <= 1'b1;
            r_gnt   <= w_win;
            r_ptr   <= w_ptr_nxt;
            r_addr  <= addr_i[w_win];
            r_wdata <= wdata_i[w_win];
            r_web   <= web_i[w_win];
`ifdef FLL_CFG_ARB_TIMEOUT_EN
            r_cnt   <= '0;
`endif
          end
        end
        S_ISSUE: begin
          if (fll_ack_i) begin
            if (r_web) r_rdata <= fll_rdata_i;
            r_req        <= 1'b0;
            r_ack[r_gnt] <= 1'b1;
            r_state      <= S_DRAIN;
          end
`ifdef FLL_CFG_ARB_TIMEOUT_EN
          else if (r_cnt == CNTW'(TIMEOUT - 1)) begin
            r_rdata      <= DATA_WIDTH'(32'hDEAD_BEEF);
            r_req        <= 1'b0;
            r_ack[r_gnt] <= 1'b1;
            r_err[r_gnt] <= 1'b1;
            r_state      <= S_DRAIN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        S_DRAIN: begin
          if (!fll_ack_i) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ack_o       = r_ack;
  assign rdata_o     = r_rdata;
  assign busy_o      = (r_state != S_IDLE);
  assign gnt_id_o    = r_gnt;
  assign fll_req_o   = r_req;
  assign fll_addr_o  = r_addr;
  assign fll_wdata_o = r_wdata;
  assign fll_web_o   = r_web;

endmodule

// File: tb/tb_fll_cfg_arbiter.sv
// Scoreboard bench for fll_cfg_arbiter: FLL responder model plus ack monitor.
module tb_fll_cfg_arbiter;

  localparam int NR = 3;

  logic            clk = 1'b0;
  logic            rst_ni;
  logic [NR-1:0]   req_i;
  logic [NR-1:0][3:0]  addr_i;
  logic [NR-1:0][31:0] wdata_i;
  logic [NR-1:0]   web_i;
  logic [NR-1:0]   ack_o;
  logic [31:0]     rdata_o;
  logic [NR-1:0]   err_o;
  logic            busy_o;
  logic [1:0]      gnt_id_o;
  logic            fll_req_o;
  logic            fll_ack_i;
  logic [3:0]      fll_addr_o;
  logic [31:0]     fll_wdata_o;
  logic            fll_web_o;
  logic [31:0]     fll_rdata_i;

  fll_cfg_arbiter #(.NR_REQ(NR), .ADDR_WIDTH(4), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .web_i(web_i), .ack_o(ack_o), .rdata_o(rdata_o), .err_o(err_o), .busy_o(busy_o),
    .gnt_id_o(gnt_id_o), .fll_req_o(fll_req_o), .fll_ack_i(fll_ack_i),
    .fll_addr_o(fll_addr_o), .fll_wdata_o(fll_wdata_o), .fll_web_o(fll_web_o),
    .fll_rdata_i(fll_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct { int id; logic [3:0] a; logic [31:0] wd; logic web; logic [31:0] rd; } fll_t;
  typedef struct { int id; logic [31:0] rd; logic err; } ack_t;

  fll_t fll_q[$];
  ack_t ack_q[$];
  int errors = 0;
  int checks = 0;
  bit fll_auto = 1'b1;
  int fll_delay = 3;
  logic [31:0] exp_rd = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected event", nm);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_fll_req"}, 32'(fll_req_o), 0);
    chk({nm, "_fll_addr"}, 32'(fll_addr_o), 0);
    chk({nm, "_fll_wdata"}, fll_wdata_o, 0);
    chk({nm, "_fll_web"}, 32'(fll_web_o), 1);
    chk({nm, "_ack"}, 32'(ack_o), 0);
    chk({nm, "_err"}, 32'(err_o), 0);
    chk({nm, "_rdata"}, rdata_o, 0);
    chk({nm, "_busy"}, 32'(busy_o), 0);
    chk({nm, "_gnt"}, 32'(gnt_id_o), 0);
  endtask

  // FLL responder: checks captured fields while req is high, acks after fll_delay cycles.
  initial begin
    int cnt = 0;
    logic prev_req = 1'b0;
    fll_t f;
    fll_ack_i   = 1'b0;
    fll_rdata_i = '0;
    forever begin
      @(posedge clk); #1;
      if (fll_auto) begin
        if (fll_ack_i) begin
          if (!fll_req_o) fll_ack_i = 1'b0;
        end else if (fll_req_o) begin
          if (cnt == 0) begin
            chk("fll_gap", 32'(prev_req), 0);
            if (fll_q.size() == 0) fail_now("fll_unexpected_req");
          end
          if (fll_q.size() != 0) begin
            f = fll_q[0];
            chk("fll_addr", 32'(fll_addr_o), 32'(f.a));
            chk("fll_wdata", fll_wdata_o, f.wd);
            chk("fll_web", 32'(fll_web_o), 32'(f.web));
            chk("fll_gnt", 32'(gnt_id_o), f.id);
          end
          cnt++;
          if (cnt >= fll_delay) begin
            fll_ack_i   = 1'b1;
            fll_rdata_i = (fll_q.size() != 0) ? fll_q.pop_front().rd : 32'h0;
            cnt = 0;
          end
        end else cnt = 0;
      end else cnt = 0;
      prev_req = fll_req_o;
    end
  end

  // Monitor: every ack pulse is matched against the head of the scoreboard.
  initial begin
    ack_t e;
    forever begin
      @(negedge clk);
      if (|ack_o) begin
        if (ack_q.size() == 0) begin
          fail_now("unexpected_ack");
        end else begin
          e = ack_q.pop_front();
          chk("ack_id", 32'(ack_o), 32'(1) << e.id);
          chk("ack_rdata", rdata_o, e.rd);
          chk("ack_err", 32'(err_o), e.err ? (32'(1) << e.id) : 32'h0);
        end
      end
    end
  end

  task automatic wait_ack(input int id);
    bit got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (ack_o[id]) got = 1'b1;
    end
    if (!got) fail_now("wait_ack");
  endtask

  task automatic wait_fll_req();
    bit got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(posedge clk); #1;
      if (fll_req_o) got = 1'b1;
    end
    if (!got) fail_now("wait_fll_req");
  endtask

  task automatic do_req(input int id, input logic [3:0] a, input logic [31:0] wd,
                        input logic web, input logic [31:0] rd, input bit disturb);
    fll_q.push_back('{id, a, wd, web, rd});
    if (web) exp_rd = rd;
    ack_q.push_back('{id, exp_rd, 1'b0});
    addr_i[id] = a; wdata_i[id] = wd; web_i[id] = web; req_i[id] = 1'b1;
    if (disturb) begin
      wait_fll_req();
      addr_i[id] = ~a; wdata_i[id] = ~wd; web_i[id] = ~web;
    end
    wait_ack(id);
    @(posedge clk); #1;
    req_i[id] = 1'b0;
  endtask

  initial begin
    int n;
    rst_ni = 1'b0; req_i = '0; addr_i = '0; wdata_i = '0; web_i = '1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    rst_ni = 1'b1;
    @(posedge clk); #1;

    // Single read from requester 0, then write from requester 1.
    fll_delay = 3;
    do_req(0, 4'hC, 32'h0, 1'b1, 32'h10030A73, 1'b0);
    chk("read_busy_idle", 32'(busy_o), 0);
    do_req(1, 4'h4, 32'h0000_1234, 1'b0, 32'hBAD0BAD0, 1'b0);
    chk("write_rdata_kept", rdata_o, 32'h10030A73);

    // Inputs change while the transfer is in flight.
    fll_delay = 4;
    do_req(0, 4'hA, 32'h5555AAAA, 1'b1, 32'h0BADF00D, 1'b1);

    // Reset in the middle of ISSUE abandons the transfer.
    fll_delay = 20;
    fll_q.push_back('{0, 4'h9, 32'h0, 1'b1, 32'h0});
    addr_i[0] = 4'h9; wdata_i[0] = 32'h0; web_i[0] = 1'b1; req_i[0] = 1'b1;
    wait_fll_req();
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b0; req_i = '0;
    @(posedge clk); #1;
    chk_reset("midreset");
    rst_ni = 1'b1;
    exp_rd = '0;
    @(posedge clk); #1;
    fll_q.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("midreset_no_req", 32'(fll_req_o), 0);

    // All requesters held high: strict rotation from pointer 0.
    fll_delay = 1;
    for (int k = 0; k < 6; k++) begin
      fll_q.push_back('{k % NR, 4'((k % NR) + 1), 32'(32'h100 * (k % NR)), 1'b1, 32'hA000_0000 + 32'(k)});
      ack_q.push_back('{k % NR, 32'hA000_0000 + 32'(k), 1'b0});
    end
    exp_rd = 32'hA000_0005;
    for (int i = 0; i < NR; i++) begin
      addr_i[i] = 4'(i + 1); wdata_i[i] = 32'(32'h100 * i); web_i[i] = 1'b1;
    end
    req_i = '1;
    n = 0;
    for (int i = 0; i < 200 && n < 6; i++) begin
      @(negedge clk);
      if (|ack_o) n++;
    end
    chk("contention_acks", n, 6);
    @(posedge clk); #1;
    req_i = '0;
    repeat (2) @(posedge clk);
    #1;

    // Stale ack in IDLE blocks the grant until it falls.
    fll_auto = 1'b0;
    fll_ack_i = 1'b1;
    fll_delay = 2;
    addr_i[0] = 4'h3; wdata_i[0] = 32'h77; web_i[0] = 1'b1; req_i[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stale_no_req", 32'(fll_req_o), 0);
    end
    fll_q.push_back('{0, 4'h3, 32'h77, 1'b1, 32'hC0FFEE01});
    exp_rd = 32'hC0FFEE01;
    ack_q.push_back('{0, exp_rd, 1'b0});
    fll_ack_i = 1'b0;
    fll_auto = 1'b1;
    @(posedge clk); #1;
    chk("stale_grant", 32'(fll_req_o), 1);
    wait_ack(0);
    @(posedge clk); #1;
    req_i[0] = 1'b0;
    @(posedge clk); #1;

`ifdef FLL_CFG_ARB_TIMEOUT_EN
    // FLL never answers: watchdog aborts after 16 ISSUE cycles.
    fll_auto = 1'b0;
    exp_rd = 32'hDEAD_BEEF;
    ack_q.push_back('{0, exp_rd, 1'b1});
    addr_i[0] = 4'h5; req_i[0] = 1'b1;
    wait_fll_req();
    n = 0;
    for (int i = 0; i < 40 && fll_req_o; i++) begin
      @(negedge clk);
      if (fll_req_o) n++;
    end
    chk("timeout_cycles", n, 16);
    @(posedge clk); #1;
    req_i[0] = 1'b0;
    fll_auto = 1'b1;
    do_req(1, 4'h6, 32'h0, 1'b1, 32'h1234_5678, 1'b0);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("ack_queue_empty", ack_q.size(), 0);
    chk("fll_queue_empty", fll_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
